tb_status_periph: RTL and testbench
===================================

TB_STATUS_PERIPH -- requirements
Module: tb_status_periph

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, stdout character FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter UNMAPPED_RDATA, default 32'hDEAD_BEEF, read data returned for unmapped offsets.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_req_i  input  1  bus request, already address-decoded by interconnect.
REQ-006 SHALL have port data_gnt_o  output  1  request accepted this cycle.
REQ-007 SHALL have port data_rvalid_o  output  1  response valid.
REQ-008 SHALL have port data_addr_i  input  32  byte address; only bits [7:0] used as offset.
REQ-009 SHALL have port data_we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port data_be_i  input  4  byte enables, ignored except STDOUT requires be[0].
REQ-011 SHALL have port data_wdata_i  input  32  write data.
REQ-012 SHALL have port data_rdata_o  output  32  read data, valid with data_rvalid_o.
REQ-013 SHALL have port char_valid_o / char_ready_i / char_data_o  output/input/output  1/1/8  stdout drain, valid/ready.
REQ-014 SHALL have ports tests_passed_o, tests_failed_o, exit_valid_o  output  1 each  test status.
REQ-015 SHALL have port exit_value_o  output  32  exit code; map_err_o  output  1  sticky unmapped-access flag.

Function
REQ-016 Register map: 0x00 STDOUT (W push wdata[7:0]; R FIFO level), 0x04 PASS (W), 0x08 FAIL (W), 0x0C EXIT (W value), 0x10 CYCLE (R), 0x14 STATUS (R {30'b0, full, empty}); other offsets unmapped.
REQ-017 data_gnt_o SHALL be combinational: data_req_i AND NOT (write to 0x00 with FIFO full); no other stall source.
REQ-018 data_rvalid_o SHALL assert exactly one cycle after each grant, for one cycle, for reads and writes; back-to-back grants yield back-to-back rvalid.
REQ-019 data_rdata_o SHALL hold captured read value during rvalid, 0 for writes, and 0 when rvalid low.
REQ-020 STDOUT write with be[0]=0 SHALL be granted and dropped; with be[0]=1 pushes wdata[7:0].
REQ-021 FIFO: char_data_o = head entry, char_valid_o = not empty; pop on char_valid_o AND char_ready_i.
REQ-022 Simultaneous push and pop SHALL both occur, level unchanged; push when full is impossible (gnt withheld); pointers wrap modulo FIFO_DEPTH.
REQ-023 FSM states RUN, DRAIN, DONE; RUN -> DRAIN on granted write to PASS, FAIL or EXIT, recording kind and (EXIT) wdata.
REQ-024 DRAIN -> DONE when FIFO empty (same cycle as final pop -> DONE next cycle); STDOUT writes in DRAIN still accepted.
REQ-025 In DONE: recorded status output (tests_passed_o, tests_failed_o, or exit_valid_o with exit_value_o) SHALL be held high as level; further PASS/FAIL/EXIT writes granted, ignored.
REQ-026 exit_value_o SHALL be 0 unless exit_valid_o high.
REQ-027 Unmapped access or read of write-only register SHALL be granted, return UNMAPPED_RDATA (reads) and set map_err_o until reset.
REQ-028 CYCLE counter: 32-bit, increments every cycle from reset release, wraps 32'hFFFF_FFFF -> 0.

Reset
REQ-029 On rst_n low, asynchronously: FIFO empty, pointers 0, FSM RUN, all outputs 0, cycle counter 0, map_err_o 0.
REQ-030 Reset mid-DRAIN or mid-transfer SHALL discard pending response and FIFO content; no rvalid after release for pre-reset grants.

Configuration
REQ-031 Macro TB_STATUS_CYCLE_CNT_EN defined: CYCLE counter implemented per REQ-028.
REQ-032 Macro undefined: no counter flops; read of 0x10 returns 0, no map_err_o.

Verification
REQ-033 Write 0x41,0x42,0x43 to 0x00, char_ready_i=1 -> char_data_o sequence 0x41,0x42,0x43, one per cycle, then char_valid_o=0.
REQ-034 char_ready_i=0, FIFO_DEPTH=8, 9 STDOUT writes -> 8 granted, 9th gnt=0 until one pop, read 0x14 = 32'h2 while full.
REQ-035 3 chars queued, char_ready_i=0, write 32'h5 to 0x0C -> exit_valid_o stays 0; release ready -> exit_valid_o=1, exit_value_o=5 one cycle after last pop.
REQ-036 Read 0x40 -> rvalid one cycle after gnt, rdata 32'hDEAD_BEEF, map_err_o=1 until reset.
REQ-037 rst_n low during DRAIN with 2 chars queued -> char_valid_o=0, FSM RUN, PASS write after release -> tests_passed_o=1 next-but-one cycle.
REQ-038 Reads of 0x10 10 cycles apart -> difference 10 with TB_STATUS_CYCLE_CNT_EN, both 0 without.

Source files
------------

// File: rtl/tb_status_periph_if.sv
// Data-bus interface of the test-status peripheral.
// The request/grant/response bundle comes from the core's data interconnect.
// The request is already address-decoded by the interconnect.
interface tb_status_periph_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;

    // Bus master side (core / interconnect / testbench).
    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o
    );

    // Peripheral side.
    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o
    );
endinterface

// File: rtl/tb_status_periph.sv
// Test-status peripheral: stdout character FIFO, PASS/FAIL/EXIT reporting,
// a free-running cycle counter and a sticky unmapped-access flag.
//
// Register map (byte offset = data_addr_i[7:0]):
//   0x00 STDOUT  W: push wdata[7:0] (needs be[0])   R: FIFO level
//   0x04 PASS    W
//   0x08 FAIL    W
//   0x0C EXIT    W: exit value
//   0x10 CYCLE   R
//   0x14 STATUS  R: {30'b0, full, empty}
//
// The test result is not reported until every queued stdout character has drained.
//
// Optional feature: define TB_STATUS_CYCLE_CNT_EN to build the 32-bit CYCLE counter.
// Without the macro, the design has no counter flops and CYCLE reads return 0.
module tb_status_periph #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                rst_n,
    tb_status_periph_if.slave   bus,
    output logic                char_valid_o,
    input  logic                char_ready_i,
    output logic [7:0]          char_data_o,
    output logic                tests_passed_o,
    output logic                tests_failed_o,
    output logic                exit_valid_o,
    output logic [31:0]         exit_value_o,
    output logic                map_err_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [7:0] OFF_STDOUT = 8'h00;
    localparam logic [7:0] OFF_PASS   = 8'h04;
    localparam logic [7:0] OFF_FAIL   = 8'h08;
    localparam logic [7:0] OFF_EXIT   = 8'h0C;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_STATUS = 8'h14;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_PASS,
        KIND_FAIL,
        KIND_EXIT
    } kind_e;

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic [7:0] offset;
    logic       is_stdout, is_pass, is_fail, is_exit, is_cycle, is_status;
    logic       is_mapped, is_write_only;

    assign offset = bus.data_addr_i[7:0];

    // Decode the byte offset into one-hot register selects.
    always_comb begin
        is_stdout     = (offset == OFF_STDOUT);
        is_pass       = (offset == OFF_PASS);
        is_fail       = (offset == OFF_FAIL);
        is_exit       = (offset == OFF_EXIT);
        is_cycle      = (offset == OFF_CYCLE);
        is_status     = (offset == OFF_STATUS);
        is_write_only = is_pass | is_fail | is_exit;
        is_mapped     = is_stdout | is_write_only | is_cycle | is_status;
    end

    // Address bits above the offset are decoded by the interconnect.
    // Only be[0] matters, because STDOUT consumes a single byte.
    logic unused_bits;
    assign unused_bits = ^{bus.data_addr_i[31:8], bus.data_be_i[3:1]};

    // ---------------------------------------------------------------
    // Stdout FIFO state and grant
    // ---------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full, fifo_empty;
    logic             grant_wr, grant_rd, push, pop;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // The only stall is a STDOUT write while the FIFO is full.
    // That stall makes a push into a full FIFO impossible.
    assign bus.data_gnt_o = bus.data_req_i
                          & ~(bus.data_we_i & is_stdout & fifo_full);

    assign grant_wr = bus.data_gnt_o &  bus.data_we_i;
    assign grant_rd = bus.data_gnt_o & ~bus.data_we_i;

    // A STDOUT write without be[0] is granted but carries no character.
    assign push = grant_wr & is_stdout & bus.data_be_i[0];
    assign pop  = char_valid_o & char_ready_i;

    assign char_valid_o = ~fifo_empty;
    assign char_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

    // Occupancy after this cycle's push/pop.
    // The drain FSM uses it to finish in the same cycle as the final pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Character storage is written on push only.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are valid.
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.data_wdata_i[7:0];
        end
    end

    // Pointers and occupancy.
    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------
    // Cycle counter (optional)
    // ---------------------------------------------------------------
    logic [31:0] cycle_value;

`ifdef TB_STATUS_CYCLE_CNT_EN
    logic [31:0] cycle_q;

    // Free-running counter; it wraps from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_q <= '0;
        else        cycle_q <= cycle_q + 32'd1;
    end

    assign cycle_value = cycle_q;
`else
    assign cycle_value = '0;
`endif

    // ---------------------------------------------------------------
    // Read mux and access-error detection
    // ---------------------------------------------------------------
    logic [31:0] rd_value;
    logic        acc_err;

    // Select read data.
    // Flag unmapped accesses and reads of write-only registers.
    always_comb begin
        rd_value = UNMAPPED_RDATA;
        if (is_stdout)      rd_value = 32'(count_q);
        else if (is_cycle)  rd_value = cycle_value;
        else if (is_status) rd_value = {30'b0, fifo_full, fifo_empty};
        acc_err = bus.data_gnt_o
                & (~is_mapped | (~bus.data_we_i & is_write_only));
    end

    // ---------------------------------------------------------------
    // Response channel: one-cycle response for every grant
    // ---------------------------------------------------------------
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        map_err_q;

    // Register the response.
    // Read data is captured at grant; writes return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            map_err_q <= 1'b0;
        end else begin
            rvalid_q  <= bus.data_gnt_o;
            rdata_q   <= grant_rd ? rd_value : 32'h0;
            map_err_q <= map_err_q | acc_err;
        end
    end

    // rdata_q is zero whenever rvalid_q is low.
    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_rdata_o  = rdata_q;
    assign map_err_o         = map_err_q;

    // ---------------------------------------------------------------
    // Status FSM: RUN -> DRAIN (result recorded) -> DONE (stdout drained)
    // ---------------------------------------------------------------
    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [31:0] exit_val_q, exit_val_d;

    // FSM state and the recorded result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            kind_q     <= KIND_NONE;
            exit_val_q <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            exit_val_q <= exit_val_d;
        end
    end

    // Next-state logic.
    // The first result write wins; later ones are granted but ignored.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        exit_val_d = exit_val_q;
        case (state_q)
            ST_RUN: begin
                if (grant_wr & is_write_only) begin
                    state_d = ST_DRAIN;
                    if (is_pass)      kind_d = KIND_PASS;
                    else if (is_fail) kind_d = KIND_FAIL;
                    else begin
                        kind_d     = KIND_EXIT;
                        exit_val_d = bus.data_wdata_i;
                    end
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign tests_passed_o = (state_q == ST_DONE) && (kind_q == KIND_PASS);
    assign tests_failed_o = (state_q == ST_DONE) && (kind_q == KIND_FAIL);
    assign exit_valid_o   = (state_q == ST_DONE) && (kind_q == KIND_EXIT);
    assign exit_value_o   = exit_valid_o ? exit_val_q : 32'h0;

endmodule

// File: tb/tb_tb_status_periph.sv
// Self-checking bench for tb_status_periph.
// Directed scenarios run first, followed by randomized bus and drain traffic.
// Every cycle is compared against a transaction-level model made of a character
// queue, a result phase and a cycle tally.
// The bench follows the TB_STATUS_CYCLE_CNT_EN macro in the same way the design does.
module tb_tb_status_periph;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        char_valid, char_ready, tests_passed, tests_failed, exit_valid, map_err;
    logic [7:0]  char_data;
    logic [31:0] exit_value;

    tb_status_periph_if bus ();

    tb_status_periph #(
        .FIFO_DEPTH     (DEPTH),
        .UNMAPPED_RDATA (UNMAPPED)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .char_valid_o   (char_valid),
        .char_ready_i   (char_ready),
        .char_data_o    (char_data),
        .tests_passed_o (tests_passed),
        .tests_failed_o (tests_failed),
        .exit_valid_o   (exit_valid),
        .exit_value_o   (exit_value),
        .map_err_o      (map_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned m_q[$];     // characters waiting to be drained
    int           m_phase;    // 0 running, 1 result recorded, 2 result reported
    int           m_kind;     // 1 pass, 2 fail, 3 exit
    logic [31:0]  m_exit;
    logic         m_err;
    logic [31:0]  m_cyc;      // cycles since reset release
    logic         m_rv;       // response expected this cycle
    logic [31:0]  m_rd;
    logic [31:0]  last_rdata;

    // One bus cycle.
    // Inputs are applied after the edge and outputs are compared 1 ns later.
    // The model then advances across the next rising edge.
    task automatic step(input logic req, input logic we, input logic [7:0] off,
                        input logic [3:0] be, input logic [31:0] wdata, input logic ready);
        logic        full, exp_gnt, pop, push;
        logic [31:0] cyc_read;
        bus.data_req_i   = req;
        bus.data_we_i    = we;
        bus.data_addr_i  = {$urandom_range(0, 32'hFF_FFFF) & 32'hFF_FFFF, 8'h00} | {24'h0, off};
        bus.data_be_i    = be;
        bus.data_wdata_i = wdata;
        char_ready       = ready;
        #1;
        full    = (m_q.size() == DEPTH);
        exp_gnt = req && !(we && off == 8'h00 && full);
        check("gnt",        bus.data_gnt_o,    exp_gnt);
        check("rvalid",     bus.data_rvalid_o, m_rv);
        check("rdata",      bus.data_rdata_o,  m_rd);
        check("char_valid", char_valid,        m_q.size() != 0);
        check("char_data",  char_data,         (m_q.size() != 0) ? m_q[0] : 0);
        check("passed",     tests_passed,      m_phase == 2 && m_kind == 1);
        check("failed",     tests_failed,      m_phase == 2 && m_kind == 2);
        check("exit_valid", exit_valid,        m_phase == 2 && m_kind == 3);
        check("exit_value", exit_value,        (m_phase == 2 && m_kind == 3) ? m_exit : 0);
        check("map_err",    map_err,           m_err);
        if (bus.data_rvalid_o) last_rdata = bus.data_rdata_o;

`ifdef TB_STATUS_CYCLE_CNT_EN
        cyc_read = m_cyc;
`else
        cyc_read = 0;
`endif
        // Response for the next cycle.
        m_rv = exp_gnt;
        m_rd = 0;
        if (exp_gnt && !we) begin
            case (off)
                8'h00:   m_rd = m_q.size();
                8'h10:   m_rd = cyc_read;
                8'h14:   m_rd = {30'b0, full, m_q.size() == 0};
                default: begin m_rd = UNMAPPED; m_err = 1'b1; end
            endcase
        end
        if (exp_gnt && we && !(off inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14}))
            m_err = 1'b1;
        // Character queue.
        pop  = (m_q.size() != 0) && ready;
        push = exp_gnt && we && off == 8'h00 && be[0];
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(wdata[7:0]);
        // Result reporting.
        if (m_phase == 0 && exp_gnt && we && off inside {8'h04, 8'h08, 8'h0C}) begin
            m_phase = 1;
            m_kind  = (off == 8'h04) ? 1 : (off == 8'h08) ? 2 : 3;
            if (off == 8'h0C) m_exit = wdata;
        end else if (m_phase == 1 && m_q.size() == 0) begin
            m_phase = 2;
        end
        m_cyc = m_cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 4'h0, 32'h0, ready);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic ready);
        step(1'b1, 1'b1, off, 4'hF, data, ready);
    endtask

    task automatic rd(input logic [7:0] off, input logic ready);
        step(1'b1, 1'b0, off, 4'hF, 32'h0, ready);
    endtask

    // Assert reset asynchronously mid-cycle and check that all outputs clear.
    // Release happens 1 ns after the following edge.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.data_req_i = 1'b0;
        char_ready     = 1'b0;
        #1;
        check("rst_gnt",        bus.data_gnt_o,    0);
        check("rst_rvalid",     bus.data_rvalid_o, 0);
        check("rst_rdata",      bus.data_rdata_o,  0);
        check("rst_char_valid", char_valid,        0);
        check("rst_char_data",  char_data,         0);
        check("rst_status",     {tests_passed, tests_failed, exit_valid, map_err}, 0);
        check("rst_exit_value", exit_value,        0);
        m_q.delete();
        m_phase = 0; m_kind = 0; m_exit = 0; m_err = 1'b0;
        m_cyc = 0; m_rv = 1'b0; m_rd = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] t1, t2;
        int          pct;
        logic [7:0]  unm [6];
        unm[0] = 8'h01; unm[1] = 8'h02; unm[2] = 8'h18;
        unm[3] = 8'h40; unm[4] = 8'h80; unm[5] = 8'hFC;

        bus.data_req_i = 1'b0; bus.data_we_i = 1'b0; bus.data_addr_i = '0;
        bus.data_be_i = '0; bus.data_wdata_i = '0; char_ready = 1'b0;
        last_rdata = '0;
        #2;
        do_reset();

        // Three characters drain in order with ready held high.
        wr(8'h00, 32'h41, 1'b1);
        wr(8'h00, 32'h42, 1'b1);
        wr(8'h00, 32'h43, 1'b1);
        idle(3, 1'b1);

        // Fill to full: the ninth write stalls until a pop, and STATUS reads 2 while full.
        do_reset();
        for (int i = 0; i < DEPTH; i++) wr(8'h00, 32'h30 + i, 1'b0);
        rd(8'h14, 1'b0);
        wr(8'h00, 32'h39, 1'b0);
        check("status_full", last_rdata, 32'h2);
        check("gnt_stall", bus.data_gnt_o, 0);
        wr(8'h00, 32'h39, 1'b1);   // pop this cycle, still full so not granted
        wr(8'h00, 32'h39, 1'b0);   // granted now
        idle(DEPTH + 2, 1'b1);

        // A STDOUT write without be[0] is granted and dropped.
        step(1'b1, 1'b1, 8'h00, 4'hE, 32'h55, 1'b0);
        idle(2, 1'b0);

        // An EXIT result is withheld until three queued characters drain.
        do_reset();
        wr(8'h00, 32'h61, 1'b0);
        wr(8'h00, 32'h62, 1'b0);
        wr(8'h00, 32'h63, 1'b0);
        wr(8'h0C, 32'h5, 1'b0);
        idle(4, 1'b0);
        check("exit_held", exit_valid, 0);
        idle(2, 1'b1);
        check("exit_before_last", exit_valid, 0);
        idle(1, 1'b1);             // last pop
        check("exit_valid_after_drain", exit_valid, 1);
        check("exit_value_after_drain", exit_value, 32'h5);
        wr(8'h04, 32'h0, 1'b1);    // ignored once done
        wr(8'h0C, 32'h9, 1'b1);
        idle(2, 1'b1);

        // Unmapped read returns the fill value and sets the sticky error.
        rd(8'h40, 1'b0);
        idle(1, 1'b0);
        check("unmapped_rdata", last_rdata, UNMAPPED);
        check("map_err_sticky", map_err, 1);
        rd(8'h04, 1'b0);           // read of a write-only register
        idle(3, 1'b0);

        // Reset during the drain phase discards queued characters and the pending result.
        do_reset();
        wr(8'h00, 32'h71, 1'b0);
        wr(8'h00, 32'h72, 1'b0);
        wr(8'h08, 32'h0, 1'b0);
        rd(8'h00, 1'b0);           // response still pending when reset hits
        do_reset();
        check("post_rst_char_valid", char_valid, 0);
        idle(1, 1'b0);
        wr(8'h04, 32'h0, 1'b0);
        check("pass_not_yet", tests_passed, 0);
        idle(1, 1'b0);
        check("pass_next_but_one", tests_passed, 1);
        check("fail_clear", tests_failed, 0);
        idle(1, 1'b0);

        // Two CYCLE reads ten cycles apart.
        rd(8'h10, 1'b0);
        idle(1, 1'b0);
        t1 = last_rdata;
        idle(8, 1'b0);
        rd(8'h10, 1'b0);
        idle(1, 1'b0);
        t2 = last_rdata;
`ifdef TB_STATUS_CYCLE_CNT_EN
        check("cycle_diff", t2 - t1, 32'd10);
`else
        check("cycle_first_zero", t1, 32'd0);
        check("cycle_second_zero", t2, 32'd0);
`endif

        // Randomized traffic; each block uses its own drain pressure.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            pct = (blk % 3 == 0) ? 15 : (blk % 3 == 1) ? 60 : 95;
            for (int c = 0; c < 500; c++) begin
                int unsigned r;
                logic        rdy;
                rdy = ($urandom_range(0, 99) < pct);
                r   = $urandom_range(0, 99);
                if (r < 45)
                    step(1'b1, 1'b1, 8'h00, 4'($urandom_range(0, 15) | ($urandom_range(0, 7) != 0 ? 1 : 0)),
                         $urandom, rdy);
                else if (r < 65)
                    rd(($urandom_range(0, 2) == 0) ? 8'h00 : ($urandom_range(0, 1) == 0) ? 8'h10 : 8'h14, rdy);
                else if (r < 68)
                    wr(8'h04 + 8'($urandom_range(0, 2) * 4), $urandom, rdy);
                else if (r < 70)
                    step(1'b1, $urandom_range(0, 1) == 1, unm[$urandom_range(0, 5)], 4'hF, $urandom, rdy);
                else
                    idle(1, rdy);
            end
            idle(DEPTH + 2, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
